fsqrt_sched: RTL

FSQRT_SCHED -- requirements
Module: fsqrt_sched

---
 rtl/fsqrt_pkg.sv | 23 ++
 rtl/fsqrt_sched_chk.sv | 26 ++
 rtl/fsqrt_sched_rr_arbiter.sv | 44 ++++
 rtl/fsqrt_sched.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fsqrt_pkg.sv
// fsqrt_pkg: shared definitions for the fsqrt request scheduler.
//   FSQRT_LAT    - latency of the shared fsqrt unit in clocks
//   FSQRT_N_REQ  - default number of requesters
//   TAG_ID_W     - width of the requester id carried in the tag pipeline
//                  (supports up to 2**TAG_ID_W requesters)
//   tag_t        - {valid, id} record travelling alongside the fsqrt pipe
//   tag_hit()    - true when a tag is valid and belongs to requester i
package fsqrt_pkg;

    localparam int FSQRT_LAT   = 3;
    localparam int FSQRT_N_REQ = 4;
    localparam int TAG_ID_W    = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic logic tag_hit(input tag_t t, input int i);
        return t.valid & (t.id == TAG_ID_W'(i));
    endfunction

endpackage

// File: rtl/fsqrt_sched_chk.sv
// fsqrt_sched_chk: assertion checker for fsqrt_sched.
//   clk, rst    - clock and active-high reset
//   cap         - per-requester capture strobe from the tag pipeline
//   resp_valid  - per-requester result-held flags
//   req_ready   - grant vector
module fsqrt_sched_chk #(
    parameter int N_REQ = 4
) (
    input logic             clk,
    input logic             rst,
    input logic [N_REQ-1:0] cap,
    input logic [N_REQ-1:0] resp_valid,
    input logic [N_REQ-1:0] req_ready
);

    // A result must never land on a requester still holding one.
    a_no_overwrite: assert property (@(posedge clk) disable iff (rst)
        ((cap & resp_valid) == '0))
        else $error("capture into a requester with resp_valid set");

    // Grant is at most one-hot.
    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready))
        else $error("req_ready is not one-hot");

endmodule

// File: rtl/fsqrt_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
//   req  [N]   - request vector
//   ptr  [IW]  - index with highest priority this cycle
//   gnt  [N]   - one-hot grant (zero when no request)
//   idx  [IW]  - index of the granted request (0 when none)
//   any        - at least one request granted
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Two passes: first look at indices at/after ptr, then wrap to the
    // start. Loop indices are constants so the search unrolls cleanly.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (IW'(i) >= ptr)) begin
                gnt[i] = 1'b1;
                idx    = IW'(i);
                any    = 1'b1;
            end else begin
                gnt[i] = gnt[i];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                gnt[i] = 1'b1;
                idx    = IW'(i);
                any    = 1'b1;
            end else begin
                gnt[i] = gnt[i];
            end
        end
    end

endmodule

// File: rtl/fsqrt_sched.sv
// fsqrt_sched: shares one external fsqrt pipeline among N_REQ requesters.
//   clk, rst          - clock, asynchronous active-high reset
//   req_valid/req_x   - per-requester request and operand
//   req_ready         - one-hot combinational grant
//   sq_x / sq_y       - operand to / result from the external fsqrt
//   resp_valid/resp_y - per-requester held result
//   resp_ack          - per-requester result consume
//   busy              - any operation in the fsqrt pipeline
// A requester may have one operation outstanding (in flight or result held);
// a tag pipeline of LAT stages tracks which requester owns each fsqrt slot.
module fsqrt_sched
    import fsqrt_pkg::*;
#(
    parameter int N_REQ = FSQRT_N_REQ,
    parameter int LAT   = FSQRT_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0][31:0] req_x,
    output logic [N_REQ-1:0]      req_ready,
    output logic [31:0]           sq_x,
    input  logic [31:0]           sq_y,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [N_REQ-1:0][31:0] resp_y,
    input  logic [N_REQ-1:0]      resp_ack,
    output logic                  busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0]           rr_ptr_r;
    logic [N_REQ-1:0]        inflight_r;
    logic [N_REQ-1:0]        resp_valid_r;
    logic [N_REQ-1:0][31:0]  resp_y_r;
    tag_t                    tag_r [LAT];

    logic [N_REQ-1:0]        eligible_s;
    logic [N_REQ-1:0]        gnt_s;
    logic [IW-1:0]           win_s;
    logic                    any_s;
    logic                    grant_s;
    logic [N_REQ-1:0]        cap_s;

    // Eligibility from registered state only; an ack in this cycle still
    // blocks a new grant until resp_valid has actually cleared.
    always_comb begin
        eligible_s = req_valid & ~inflight_r & ~resp_valid_r;
    end

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req (eligible_s),
        .ptr (rr_ptr_r),
        .gnt (gnt_s),
        .idx (win_s),
        .any (any_s)
    );

    // Grant outputs; held at zero while reset is asserted.
    always_comb begin
        grant_s = any_s & ~rst;
        if (grant_s) begin
            req_ready = gnt_s;
            sq_x      = req_x[win_s];
        end else begin
            req_ready = '0;
            sq_x      = 32'h0;
        end
    end

    // Capture strobes from the last tag stage, aligned with sq_y.
    always_comb begin
        cap_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cap_s[i] = tag_hit(tag_r[LAT-1], i);
        end
    end

    // Busy while any tag stage holds a live operation.
    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            busy = busy | tag_r[s].valid;
        end
    end

    // Round-robin pointer: winner+1 on grant, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (grant_s) begin
            rr_ptr_r <= (win_s == IW'(N_REQ - 1)) ? '0 : win_s + IW'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Tag pipeline advances every clock; reset discards in-flight results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                tag_r[s] <= '0;
            end
        end else begin
            tag_r[0] <= '{valid: grant_s, id: TAG_ID_W'(win_s)};
            for (int s = 1; s < LAT; s++) begin
                tag_r[s] <= tag_r[s-1];
            end
        end
    end

    // Per-requester outstanding state: in-flight, result-held flag, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r   <= '0;
            resp_valid_r <= '0;
            resp_y_r     <= '0;
        end else begin
            inflight_r   <= (inflight_r | (grant_s ? gnt_s : '0)) & ~cap_s;
            resp_valid_r <= (resp_valid_r & ~resp_ack) | cap_s;
            for (int i = 0; i < N_REQ; i++) begin
                if (cap_s[i]) begin
                    resp_y_r[i] <= sq_y;
                end else begin
                    resp_y_r[i] <= resp_y_r[i];
                end
            end
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_y     = resp_y_r;

    fsqrt_sched_chk #(.N_REQ(N_REQ)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .cap        (cap_s),
        .resp_valid (resp_valid_r),
        .req_ready  (req_ready)
    );

endmodule
